gpr_mp: RTL and testbench

Parametrised multi-read-port general purpose register file with a per-register pending-write scoreboard and a post-reset clear sequencer. It replaces the fixed 32x32 2R/1W register file in the core's decode/writeback path. Decode reads operands and busy status through NRD combinational ports and marks destinations busy at issue. Writeback writes results, which are forwarded to the read ports in the same cycle.

---
 rtl/gpr_mp.sv | 131 +++++++++++++
 tb/tb_gpr_mp.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpr_mp.sv
// Multi-read-port register file with a pending-write (busy) scoreboard.
// After reset a sequencer zeroes every register before ready rises.
module gpr_mp #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [XLEN-1:0]     wdata,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    input  logic                flush
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
    localparam logic [AW:0]   NREG_L   = (AW + 1)'(NREG);

    state_t          state, state_nxt;
    logic [AW-1:0]   clr_idx, clr_idx_nxt;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] busy, busy_nxt;
    logic            run_we;
    logic [AW-1:0]   ra;

    // An address is live when it is inside the array and not the hardwired zero register.
    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREG_L) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            CLEAR: begin
                clr_idx_nxt = clr_idx + 1'b1;
                if (clr_idx == LAST_IDX) begin
                    state_nxt   = RUN;
                    clr_idx_nxt = '0;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt   = CLEAR;
                clr_idx_nxt = '0;
            end
        endcase
    end

    // The state register doubles as the registered ready flag.
    assign ready  = (state == RUN);
    assign run_we = (state == RUN) && we && addr_ok(waddr);

    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_idx] <= '0;
        end else if (run_we) begin
            mem[waddr] <= wdata;
        end
    end

    // Flush beats set, and set beats a same-cycle writeback since a newer producer issued.
    always_comb begin
        busy_nxt = busy;
        if (state == RUN) begin
            for (int i = 0; i < NREG; i++) begin
                if (flush) begin
                    busy_nxt[i] = 1'b0;
                end else if (set_en && (set_addr == AW'(i))) begin
                    busy_nxt[i] = 1'b1;
                end else if (we && (waddr == AW'(i))) begin
                    busy_nxt[i] = 1'b0;
                end
            end
            if (ZERO_REG != 0) begin
                busy_nxt[0] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        rbusy = '0;
        ra    = '0;
        for (int p = 0; p < NRD; p++) begin
            ra = raddr[p*AW +: AW];
            if ((state == RUN) && addr_ok(ra)) begin
                if (we && (waddr == ra)) begin
                    rdata[p*XLEN +: XLEN] = wdata;
                end else begin
                    rdata[p*XLEN +: XLEN] = mem[ra];
                    rbusy[p]              = busy[ra];
                end
            end
        end
    end

endmodule

// File: tb/tb_gpr_mp.sv
// Bench for gpr_mp: a 32-entry/2-port and a 24-entry/3-port instance share one
// stimulus stream and are both compared against an array-based reference model.
module tb_gpr_mp;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              we, set_en, flush;
  logic [AW-1:0]     waddr, set_addr;
  logic [XLEN-1:0]   wdata;
  logic [2*AW-1:0]   raddr_a;
  logic [2*XLEN-1:0] rdata_a;
  logic [1:0]        rbusy_a;
  logic              ready_a;
  logic [3*AW-1:0]   raddr_b;
  logic [3*XLEN-1:0] rdata_b;
  logic [2:0]        rbusy_b;
  logic              ready_b;

  gpr_mp #(.XLEN(XLEN), .NREG(32), .NRD(2), .ZERO_REG(1)) dut_a (
    .clk(clk), .rst(rst), .ready(ready_a), .raddr(raddr_a), .rdata(rdata_a),
    .rbusy(rbusy_a), .we(we), .waddr(waddr), .wdata(wdata), .set_en(set_en),
    .set_addr(set_addr), .flush(flush)
  );

  gpr_mp #(.XLEN(XLEN), .NREG(24), .NRD(3), .ZERO_REG(1)) dut_b (
    .clk(clk), .rst(rst), .ready(ready_b), .raddr(raddr_b), .rdata(rdata_b),
    .rbusy(rbusy_b), .we(we), .waddr(waddr), .wdata(wdata), .set_en(set_en),
    .set_addr(set_addr), .flush(flush)
  );

  // reference model: index 0 = dut_a, index 1 = dut_b
  int            nreg [2] = '{32, 24};
  int            nrd  [2] = '{2, 3};
  logic [XLEN-1:0] m_mem [2][32];
  bit            m_busy [2][32];
  bit            m_run [2];
  int            m_cnt [2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int raddr_of(input int k, input int p);
    return (k == 0) ? int'(raddr_a[p*AW +: AW]) : int'(raddr_b[p*AW +: AW]);
  endfunction

  function automatic logic [XLEN-1:0] rdata_of(input int k, input int p);
    return (k == 0) ? rdata_a[p*XLEN +: XLEN] : rdata_b[p*XLEN +: XLEN];
  endfunction

  function automatic logic rbusy_of(input int k, input int p);
    return (k == 0) ? rbusy_a[p] : rbusy_b[p];
  endfunction

  function automatic bit live(input int k, input int a);
    return (a < nreg[k]) && (a != 0);
  endfunction

  function automatic logic [XLEN-1:0] exp_rdata(input int k, input int a);
    if (!m_run[k] || !live(k, a)) return '0;
    if (we && int'(waddr) == a) return wdata;
    return m_mem[k][a];
  endfunction

  function automatic logic exp_rbusy(input int k, input int a);
    if (!m_run[k] || !live(k, a)) return 1'b0;
    if (we && int'(waddr) == a) return 1'b0;
    return m_busy[k][a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 1'b0;
      m_cnt[k] = 0;
      for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int wa, sa;
    wa = int'(waddr);
    sa = int'(set_addr);
    for (int k = 0; k < 2; k++) begin
      if (!m_run[k]) begin
        m_cnt[k]++;
        if (m_cnt[k] == nreg[k]) begin
          m_run[k] = 1'b1;
          for (int i = 0; i < 32; i++) m_mem[k][i] = '0;
        end
      end else begin
        if (we && live(k, wa)) m_mem[k][wa] = wdata;
        if (flush) begin
          for (int i = 0; i < 32; i++) m_busy[k][i] = 1'b0;
        end else begin
          if (we && live(k, wa)) m_busy[k][wa] = 1'b0;
          if (set_en && live(k, sa)) m_busy[k][sa] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    int a;
    check("ready_a", ready_a, m_run[0]);
    check("ready_b", ready_b, m_run[1]);
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < nrd[k]; p++) begin
        a = raddr_of(k, p);
        check($sformatf("rdata%0d_p%0d_r%0d", k, p, a), rdata_of(k, p), exp_rdata(k, a));
        check($sformatf("rbusy%0d_p%0d_r%0d", k, p, a), rbusy_of(k, p), exp_rbusy(k, a));
      end
    end
  endtask

  // half: sample at the falling edge; edge_: advance the model across the rising edge
  task automatic half();
    @(negedge clk);
    compare_all();
  endtask

  task automatic edge_();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    half();
    edge_();
  endtask

  task automatic idle();
    we = 1'b0; set_en = 1'b0; flush = 1'b0;
    waddr = '0; set_addr = '0; wdata = '0;
  endtask

  task automatic rand_cycle();
    we       = 1'($urandom_range(0, 1));
    waddr    = AW'($urandom_range(0, 31));
    wdata    = $urandom;
    set_en   = ($urandom_range(0, 2) == 0);
    set_addr = AW'($urandom_range(0, 31));
    flush    = ($urandom_range(0, 19) == 0);
    for (int p = 0; p < 2; p++)
      raddr_a[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
    for (int p = 0; p < 3; p++)
      raddr_b[p*AW +: AW] = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, 31));
    step();
  endtask

  initial begin
    idle();
    raddr_a = '0;
    raddr_b = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready_a", ready_a, 1'b0);
    check("reset_rbusy_a", rbusy_a, 2'b00);
    check("reset_rdata_a", rdata_a, '0);

    // clear sequence with a write attempt that must be ignored by dut_a
    we = 1'b1; waddr = 5'd5; wdata = 32'hAAAA_5555;
    raddr_a = {5'd5, 5'd5};
    raddr_b = {5'd5, 5'd5, 5'd5};
    rst = 1'b1;
    repeat (32) step();
    we = 1'b0;
    half();
    check("clear_done_ready", ready_a, 1'b1);
    check("clear_ignores_we", rdata_a[31:0], 32'h0);
    edge_();

    // write bypass and storage
    we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
    raddr_a = {5'd3, 5'd3};
    raddr_b = {5'd3, 5'd3, 5'd3};
    half();
    check("bypass_p0", rdata_a[31:0], 32'hDEADBEEF);
    check("bypass_p1", rdata_a[63:32], 32'hDEADBEEF);
    edge_();
    we = 1'b0;
    half();
    check("stored_p0", rdata_a[31:0], 32'hDEADBEEF);
    check("stored_p1", rdata_a[63:32], 32'hDEADBEEF);
    edge_();

    // zero register
    we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
    raddr_a = '0;
    raddr_b = '0;
    step();
    we = 1'b0; set_en = 1'b1; set_addr = 5'd0;
    half();
    check("zero_rdata", rdata_a[31:0], 32'h0);
    edge_();
    set_en = 1'b0;
    half();
    check("zero_rbusy", rbusy_a[0], 1'b0);
    edge_();

    // scoreboard set / writeback / set-wins
    set_en = 1'b1; set_addr = 5'd7;
    raddr_a = {5'd7, 5'd7};
    raddr_b = {5'd7, 5'd7, 5'd7};
    step();
    set_en = 1'b0;
    half();
    check("set_busy", rbusy_a[0], 1'b1);
    edge_();
    we = 1'b1; waddr = 5'd7; wdata = $urandom;
    half();
    check("wb_hides_busy", rbusy_a[0], 1'b0);
    edge_();
    we = 1'b0;
    half();
    check("wb_clears_busy", rbusy_a[1], 1'b0);
    edge_();
    set_en = 1'b1; set_addr = 5'd7; we = 1'b1; waddr = 5'd7; wdata = $urandom;
    step();
    set_en = 1'b0; we = 1'b0;
    half();
    check("set_wins", rbusy_a[0], 1'b1);
    edge_();

    // flush overrides a simultaneous set
    set_en = 1'b1;
    set_addr = 5'd2;  step();
    set_addr = 5'd9;  step();
    set_addr = 5'd31; step();
    set_en = 1'b0;
    raddr_a = {5'd31, 5'd9};
    raddr_b = {5'd31, 5'd9, 5'd2};
    half();
    check("pre_flush_busy", rbusy_a, 2'b11);
    edge_();
    flush = 1'b1; set_en = 1'b1; set_addr = 5'd4;
    step();
    flush = 1'b0; set_en = 1'b0;
    raddr_a = {5'd4, 5'd2};
    half();
    check("flush_busy_2_4", rbusy_a, 2'b00);
    edge_();
    raddr_a = {5'd31, 5'd9};
    half();
    check("flush_busy_9_31", rbusy_a, 2'b00);
    edge_();

    // out-of-range write on the 24-entry instance
    we = 1'b1; waddr = 5'd30; wdata = 32'hCAFE_F00D;
    step();
    we = 1'b0;
    raddr_b = {5'd30, 5'd30, 5'd30};
    half();
    check("oor_rdata_b", rdata_b[31:0], 32'h0);
    edge_();

    repeat (400) rand_cycle();

    // asynchronous reset between clock edges
    idle();
    set_en = 1'b1; set_addr = 5'd7;
    step();
    set_en = 1'b0;
    raddr_a = {5'd7, 5'd7};
    #2 rst = 1'b0;
    #1;
    check("async_ready_a", ready_a, 1'b0);
    check("async_ready_b", ready_b, 1'b0);
    check("async_rbusy_a", rbusy_a, 2'b00);
    check("async_rdata_a", rdata_a, '0);
    model_reset();
    rst = 1'b1;
    repeat (34) step();
    check("restart_busy_cleared", rbusy_a, 2'b00);

    repeat (150) rand_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
